// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - two-channel round-robin arbiter feeding a registered 2:1 mux output
// Optional per-channel transfer counters: define MUX2_RR_ARBITER_STATS_EN

module mux2_rr_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic [WIDTH-1:0] y_data,
   output logic             y_valid,
   input  logic             y_ready,
   output logic             sel
`ifdef MUX2_RR_ARBITER_STATS_EN
   ,
   output logic [15:0]      a_count,
   output logic [15:0]      b_count
`endif
);

   // EMPTY: output register holds nothing; FULL: output register holds an unconsumed word
   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_y_data;
   logic             r_sel;
   logic             r_last_grant;

   logic             w_load;
   logic             w_grant_a;
   logic             w_grant_b;
   logic             w_grant_any;
   logic             w_grant_idx;
   logic [WIDTH-1:0] w_grant_data;

   // Grant decision: a lone requester always wins, contention goes to the channel not served last
   always_comb begin
      w_load       = (r_state == S_EMPTY) || y_ready;
      w_grant_a    = 1'b0;
      w_grant_b    = 1'b0;
      case ({a_valid, b_valid})
         2'b10:   w_grant_a = 1'b1;
         2'b01:   w_grant_b = 1'b1;
         2'b11: begin
            w_grant_a = r_last_grant;
            w_grant_b = !r_last_grant;
         end
         default: begin
            w_grant_a = 1'b0;
            w_grant_b = 1'b0;
         end
      endcase
      w_grant_any  = w_grant_a || w_grant_b;
      w_grant_idx  = w_grant_b;
      w_grant_data = w_grant_b ? b_data : a_data;
   end

   // Ready only when the output register can take a word, so a_ready and b_ready are exclusive
   assign a_ready = w_load && w_grant_a;
   assign b_ready = w_load && w_grant_b;

   // Output-register FSM; last_grant moves only when a word actually transfers in
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_EMPTY;
         r_y_data     <= '0;
         r_sel        <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_grant_any) begin
                  r_y_data     <= w_grant_data;
                  r_sel        <= w_grant_idx;
                  r_last_grant <= w_grant_idx;
                  r_state      <= S_FULL;
               end
            end
            S_FULL: begin
               if (y_ready) begin
                  if (w_grant_any) begin
                     // consume and refill in the same edge: no bubble
                     r_y_data     <= w_grant_data;
                     r_sel        <= w_grant_idx;
                     r_last_grant <= w_grant_idx;
                     r_state      <= S_FULL;
                  end else begin
                     // drained; data and sel keep their last values
                     r_state <= S_EMPTY;
                  end
               end
            end
            default: r_state <= S_EMPTY;
         endcase
      end
   end

   assign y_data  = r_y_data;
   assign y_valid = (r_state == S_FULL);
   assign sel     = r_sel;

`ifdef MUX2_RR_ARBITER_STATS_EN
   logic [15:0] r_a_count;
   logic [15:0] r_b_count;

   // Per-channel transfer counters, wrapping naturally at 16 bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a_count <= '0;
         r_b_count <= '0;
      end else begin
         if (a_ready) r_a_count <= r_a_count + 16'd1;
         if (b_ready) r_b_count <= r_b_count + 16'd1;
      end
   end

   assign a_count = r_a_count;
   assign b_count = r_b_count;
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - scoreboard bench for mux2_rr_arbiter with a queue-based reference model

module tb_mux2_rr_arbiter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] a_data = '0;
   logic       a_valid = 1'b0;
   logic       a_ready;
   logic [7:0] b_data = '0;
   logic       b_valid = 1'b0;
   logic       b_ready;
   logic [7:0] y_data;
   logic       y_valid;
   logic       y_ready = 1'b0;
   logic       sel;
`ifdef MUX2_RR_ARBITER_STATS_EN
   logic [15:0] a_count;
   logic [15:0] b_count;
`endif

   mux2_rr_arbiter #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .a_data  (a_data),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .b_data  (b_data),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .y_data  (y_data),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .sel     (sel)
`ifdef MUX2_RR_ARBITER_STATS_EN
      ,
      .a_count (a_count),
      .b_count (b_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: words in flight {sel, data}, which channel was served last, transfer tallies
   logic [8:0] sb_q[$];
   logic       m_last = 1'b1;
   int         m_acnt = 0;
   int         m_bcnt = 0;
   logic       exp_a_ready = 1'b0;
   logic       exp_b_ready = 1'b0;
   logic       exp_y_valid = 1'b0;
   logic       mon_en = 1'b0;
   logic [8:0] mon_e;

   logic       r_av = 1'b0, r_bv = 1'b0, r_yr = 1'b0;
   logic [7:0] r_ad = '0, r_bd = '0;
   logic [7:0] con_exp [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs and predict what the arbiter must do with them
   task automatic cycle(input logic av, input logic [7:0] ad, input logic bv,
                        input logic [7:0] bd, input logic yr);
      logic load, ga, gb;
      @(posedge clk);
      #1;
      a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
      exp_y_valid = (sb_q.size() != 0);
      load = (sb_q.size() == 0) || yr;
      ga = av && (!bv || m_last);
      gb = bv && (!av || !m_last);
      exp_a_ready = load && ga;
      exp_b_ready = load && gb;
      if (exp_a_ready) begin
         sb_q.push_back({1'b0, ad});
         m_last = 1'b0;
         m_acnt++;
      end else if (exp_b_ready) begin
         sb_q.push_back({1'b1, bd});
         m_last = 1'b1;
         m_bcnt++;
      end
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_y_valid"}, 32'(y_valid), 32'd0);
      chk({tag, "_y_data"},  32'(y_data),  32'd0);
      chk({tag, "_sel"},     32'(sel),     32'd0);
`ifdef MUX2_RR_ARBITER_STATS_EN
      chk({tag, "_a_count"}, 32'(a_count), 32'd0);
      chk({tag, "_b_count"}, 32'(b_count), 32'd0);
`endif
   endtask

   // Asynchronous reset between clock edges; outputs must clear without waiting for a clock
   task automatic do_reset(input string tag);
      @(negedge clk);
      #2;
      reset = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
      #1;
      chk_cleared(tag);
      sb_q.delete();
      m_last = 1'b1;
      m_acnt = 0;
      m_bcnt = 0;
      exp_a_ready = 1'b0; exp_b_ready = 1'b0; exp_y_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: handshake and occupancy checks every cycle, pops the scoreboard on each consume
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         chk("a_ready", 32'(a_ready), 32'(exp_a_ready));
         chk("b_ready", 32'(b_ready), 32'(exp_b_ready));
         chk("y_valid", 32'(y_valid), 32'(exp_y_valid));
         chk("ready_excl", 32'(a_ready && b_ready), 32'd0);
         if (y_valid && y_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_output", 32'(y_data), 32'hFFFF_FFFF);
            end else begin
               mon_e = sb_q.pop_front();
               chk("y_data", 32'(y_data), 32'(mon_e[7:0]));
               chk("sel",    32'(sel),    32'(mon_e[8]));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with random inputs
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         a_valid = 1'($urandom); a_data = 8'($urandom);
         b_valid = 1'($urandom); b_data = 8'($urandom);
         y_ready = 1'($urandom);
         #1;
         chk_cleared("rst");
      end
      @(posedge clk);
      #1;
      a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
      reset = 1'b0;
      #1;
      chk_cleared("post_rst");
      chk("post_rst_a_ready", 32'(a_ready), 32'd0);
      chk("post_rst_b_ready", 32'(b_ready), 32'd0);
      mon_en = 1'b1;

      // A only
      cycle(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1);
      #1;
      chk("a_only_ready", 32'(a_ready), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("a_only_y_data",  32'(y_data),  32'hA5);
      chk("a_only_y_valid", 32'(y_valid), 32'd1);
      chk("a_only_sel",     32'(sel),     32'd0);

      // Contention from a fresh reset: A first, then alternating
      do_reset("rst1");
      con_exp[0] = 8'h11; con_exp[1] = 8'h22; con_exp[2] = 8'h11; con_exp[3] = 8'h22;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
         if (i > 0) begin
            chk("contend_data", 32'(y_data), 32'(con_exp[i-1]));
            chk("contend_sel",  32'(sel),    32'(i[0] ? 1'b0 : 1'b1));
         end
      end

      // Drain: last contention word visible, then y_valid drops with data and sel held
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("contend_last_data", 32'(y_data), 32'h22);
      chk("contend_last_sel",  32'(sel),    32'd1);
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk("drain_y_valid", 32'(y_valid), 32'd0);
      chk("drain_y_data",  32'(y_data),  32'h22);
      chk("drain_sel",     32'(sel),     32'd1);

      // Backpressure with 3C held, then a no-bubble reload
      cycle(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
         chk("bp_y_data", 32'(y_data), 32'h3C);
         #1;
         chk("bp_a_ready", 32'(a_ready), 32'd0);
      end
      cycle(1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
      #1;
      chk("bp_release_a_ready", 32'(a_ready), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      chk("bp_reload_data",  32'(y_data),  32'h77);
      chk("bp_reload_valid", 32'(y_valid), 32'd1);

      // 5 A and 3 B transfers, word left held, then asynchronous reset discards it
      do_reset("rst2");
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 8'(8'h80 + i), 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk("model_a_transfers", 32'(m_acnt), 32'd5);
      chk("model_b_transfers", 32'(m_bcnt), 32'd3);
      chk("held_y_data", 32'(y_data), 32'h82);
`ifdef MUX2_RR_ARBITER_STATS_EN
      chk("a_count", 32'(a_count), 32'(m_acnt));
      chk("b_count", 32'(b_count), 32'(m_bcnt));
`endif
      do_reset("rst3");

      // Randomized traffic; a pending word keeps its data until accepted
      r_av = 1'b0; r_bv = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!r_av || exp_a_ready) begin
            r_av = ($urandom_range(0, 99) < 60);
            r_ad = 8'($urandom);
         end
         if (!r_bv || exp_b_ready) begin
            r_bv = ($urandom_range(0, 99) < 60);
            r_bd = 8'($urandom);
         end
         r_yr = ($urandom_range(0, 99) < 70);
         cycle(r_av, r_ad, r_bv, r_bd, r_yr);
      end
      r_av = r_av && !exp_a_ready;
      r_bv = r_bv && !exp_b_ready;
      for (int i = 0; i < 6; i++) begin
         cycle(r_av, r_ad, r_bv, r_bd, 1'b1);
         r_av = r_av && !exp_a_ready;
         r_bv = r_bv && !exp_b_ready;
      end
`ifdef MUX2_RR_ARBITER_STATS_EN
      chk("rand_a_count", 32'(a_count), 32'(m_acnt));
      chk("rand_b_count", 32'(b_count), 32'(m_bcnt));
`endif
      @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
